// File: rtl/fetch_stage_unit.sv
`timescale 1ns/1ps
// fetch_stage_unit
// ----------------
// Instruction-fetch stage. Owns the PC and the single-outstanding-request
// handshake with instruction memory, and drives the IF/ID pipeline register.
// Stall controls come from the hazard unit; a resolved branch redirect
// overrides any stall. A word that returns while the pipeline is stalled is
// parked in a hold register. A request still in flight when a redirect
// arrives is drained and its data dropped. Slow memory produces bubbles.
//
// Ports
//   Clock            rising-edge clock for all state
//   Reset            synchronous, active-low (0 = reset)
//   PCWriteEnable    hazard unit: 0 holds the PC
//   IFIDWriteEnable  hazard unit: 0 holds the IF/ID register
//   Branch           taken redirect, overrides stalls and flushes IF/ID
//   BranchTarget     redirect address (low two bits forced to 0)
//   IMemReady        memory data valid / request complete this cycle
//   IMemData         returned instruction word
//   IMemReq          request outstanding (decoded from registered state)
//   IMemAddr         fetch address, stable while a request is outstanding
//   IFIDInstruction  instruction handed to ID
//   IFIDPCPlus4      address of that instruction + 4
//   IFIDValid        0 marks a bubble
//   PCOut            architectural PC
module fetch_stage_unit #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter logic [31:0] NOP_WORD = 32'h00000000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        PCWriteEnable,
    input  logic        IFIDWriteEnable,
    input  logic        Branch,
    input  logic [31:0] BranchTarget,
    input  logic        IMemReady,
    input  logic [31:0] IMemData,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    output logic [31:0] IFIDInstruction,
    output logic [31:0] IFIDPCPlus4,
    output logic        IFIDValid,
    output logic [31:0] PCOut
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        DRAIN
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] fetch_addr;
    logic [31:0] hold_reg;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;

    logic [31:0] branch_addr;
    logic [31:0] fetch_next;
    logic        both_en;
    logic        unused_target_bits;

    // Redirect targets are always word aligned; the low bits are discarded.
    assign branch_addr        = {BranchTarget[31:2], 2'b00};
    assign unused_target_bits = ^BranchTarget[1:0];
    assign fetch_next         = fetch_addr + 32'd4;
    assign both_en            = PCWriteEnable & IFIDWriteEnable;

    // Request is purely a decode of the registered state, so memory never
    // sees a combinational path from this cycle's hazard/branch inputs.
    assign IMemReq         = (state == FETCH) || (state == DRAIN);
    assign IMemAddr        = fetch_addr;
    assign IFIDInstruction = ifid_instr;
    assign IFIDPCPlus4     = ifid_pc4;
    assign IFIDValid       = ifid_valid;
    assign PCOut           = pc;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            fetch_addr <= RESET_PC;
            hold_reg   <= 32'h0;
            ifid_instr <= NOP_WORD;
            ifid_pc4   <= 32'h0;
            ifid_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    fetch_addr <= pc;
                    state      <= FETCH;
                end

                FETCH: begin
                    if (Branch) begin
                        // A same-cycle return belongs to the wrong path and is
                        // dropped; otherwise the request must be drained.
                        pc         <= branch_addr;
                        ifid_instr <= NOP_WORD;
                        ifid_valid <= 1'b0;
                        if (IMemReady) begin
                            fetch_addr <= branch_addr;
                        end else begin
                            state <= DRAIN;
                        end
                    end else if (IMemReady) begin
                        if (both_en) begin
                            ifid_instr <= IMemData;
                            ifid_pc4   <= fetch_next;
                            ifid_valid <= 1'b1;
                            pc         <= fetch_next;
                            fetch_addr <= fetch_next;
                        end else begin
                            // Memory cannot be asked to repeat, so park the word.
                            hold_reg <= IMemData;
                            state    <= HOLD;
                        end
                    end else if (IFIDWriteEnable) begin
                        ifid_instr <= NOP_WORD;
                        ifid_valid <= 1'b0;
                    end
                end

                HOLD: begin
                    if (Branch) begin
                        pc         <= branch_addr;
                        fetch_addr <= branch_addr;
                        ifid_instr <= NOP_WORD;
                        ifid_valid <= 1'b0;
                        state      <= FETCH;
                    end else if (both_en) begin
                        ifid_instr <= hold_reg;
                        ifid_pc4   <= fetch_next;
                        ifid_valid <= 1'b1;
                        pc         <= fetch_next;
                        fetch_addr <= fetch_next;
                        state      <= FETCH;
                    end
                end

                DRAIN: begin
                    // IMemAddr keeps the stale address until memory answers;
                    // the newest redirect target is the one fetched next.
                    if (Branch) begin
                        pc <= branch_addr;
                    end
                    if (IMemReady) begin
                        fetch_addr <= Branch ? branch_addr : pc;
                        state      <= FETCH;
                    end
                    if (Branch || IFIDWriteEnable) begin
                        ifid_instr <= NOP_WORD;
                        ifid_valid <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage_unit.sv
`timescale 1ns/1ps
// Bench for fetch_stage_unit: directed scenarios with literal expectations,
// then a long randomized run against a transaction-level model of the stage.
module tb_fetch_stage_unit;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        PCWriteEnable;
    logic        IFIDWriteEnable;
    logic        Branch;
    logic [31:0] BranchTarget;
    logic        IMemReady;
    logic [31:0] IMemData;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic [31:0] IFIDInstruction;
    logic [31:0] IFIDPCPlus4;
    logic        IFIDValid;
    logic [31:0] PCOut;

    localparam logic [31:0] NOP = 32'h00000000;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Model: what the stage is doing in terms of fetch transactions.
    logic [31:0] m_pc, m_fetch, m_hold_word, m_instr, m_pc4;
    bit          m_valid, m_started, m_waiting, m_wrong_path, m_have_word;

    // Memory responder bookkeeping for the random phase.
    bit mem_busy = 1'b0;
    int mem_wait = 0;

    always #5 Clock = ~Clock;

    fetch_stage_unit #(.RESET_PC(32'h00000000), .NOP_WORD(32'h00000000)) dut (
        .Clock(Clock),
        .Reset(Reset),
        .PCWriteEnable(PCWriteEnable),
        .IFIDWriteEnable(IFIDWriteEnable),
        .Branch(Branch),
        .BranchTarget(BranchTarget),
        .IMemReady(IMemReady),
        .IMemData(IMemData),
        .IMemReq(IMemReq),
        .IMemAddr(IMemAddr),
        .IFIDInstruction(IFIDInstruction),
        .IFIDPCPlus4(IFIDPCPlus4),
        .IFIDValid(IFIDValid),
        .PCOut(PCOut)
    );

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'hA5A50000 ^ a;
    endfunction

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_bubble();
        m_instr = NOP;
        m_valid = 1'b0;
    endtask

    task automatic model_deliver(input logic [31:0] w);
        m_instr = w;
        m_pc4   = m_fetch + 32'd4;
        m_valid = 1'b1;
        m_fetch = m_fetch + 32'd4;
        m_pc    = m_fetch;
    endtask

    // One clock edge of the stage, described per fetch transaction.
    task automatic modelStep();
        logic [31:0] tgt;
        tgt = BranchTarget & ~32'h3;
        if (!Reset) begin
            m_pc = 32'h0; m_fetch = 32'h0; m_hold_word = 32'h0;
            m_instr = NOP; m_pc4 = 32'h0; m_valid = 1'b0;
            m_started = 1'b0; m_waiting = 1'b0; m_wrong_path = 1'b0; m_have_word = 1'b0;
        end else if (!m_started) begin
            m_started = 1'b1;
            m_waiting = 1'b1;
            m_fetch   = m_pc;
        end else if (m_have_word) begin
            if (Branch) begin
                m_pc = tgt; m_fetch = tgt;
                model_bubble();
                m_have_word = 1'b0; m_waiting = 1'b1;
            end else if (PCWriteEnable && IFIDWriteEnable) begin
                model_deliver(m_hold_word);
                m_have_word = 1'b0; m_waiting = 1'b1;
            end
        end else if (m_wrong_path) begin
            if (Branch) m_pc = tgt;
            if (IMemReady) begin
                m_fetch = m_pc;
                m_wrong_path = 1'b0;
            end
            if (Branch || IFIDWriteEnable) model_bubble();
        end else begin
            if (Branch) begin
                m_pc = tgt;
                model_bubble();
                if (IMemReady) m_fetch = tgt;
                else m_wrong_path = 1'b1;
            end else if (IMemReady && PCWriteEnable && IFIDWriteEnable) begin
                model_deliver(IMemData);
            end else if (IMemReady) begin
                m_hold_word = IMemData;
                m_have_word = 1'b1;
                m_waiting   = 1'b0;
            end else if (IFIDWriteEnable) begin
                model_bubble();
            end
        end
    endtask

    // Every-cycle comparison of all outputs against the model.
    task automatic checkOutput();
        compare("IMemReq", {31'b0, IMemReq}, {31'b0, m_waiting});
        compare("IMemAddr", IMemAddr, m_fetch);
        compare("PCOut", PCOut, m_pc);
        compare("IFIDValid", {31'b0, IFIDValid}, {31'b0, m_valid});
        compare("IFIDInstruction", IFIDInstruction, m_instr);
        if (m_valid) compare("IFIDPCPlus4", IFIDPCPlus4, m_pc4);
    endtask

    task automatic applyStimulus(input logic rst, input logic pcwe, input logic ifidwe,
                                 input logic br, input logic [31:0] tgt,
                                 input logic rdy, input logic [31:0] data);
        Reset           = rst;
        PCWriteEnable   = pcwe;
        IFIDWriteEnable = ifidwe;
        Branch          = br;
        BranchTarget    = tgt;
        IMemReady       = rdy;
        IMemData        = data;
    endtask

    task automatic applyRandom();
        Reset           = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
        PCWriteEnable   = ($urandom_range(0, 9) < 8);
        IFIDWriteEnable = ($urandom_range(0, 9) < 8);
        Branch          = ($urandom_range(0, 11) == 0);
        BranchTarget    = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFF0 | $urandom_range(0, 15)) : $urandom;
        if (IMemReq) begin
            if (!mem_busy) begin
                mem_busy = 1'b1;
                mem_wait = $urandom_range(0, 3);
            end
            if (mem_wait == 0) begin
                IMemReady = 1'b1;
                IMemData  = word_at(IMemAddr);
                mem_busy  = 1'b0;
            end else begin
                IMemReady = 1'b0;
                IMemData  = $urandom;
                mem_wait--;
            end
        end else begin
            mem_busy  = 1'b0;
            IMemReady = ($urandom_range(0, 9) == 0);
            IMemData  = $urandom;
        end
    endtask

    task automatic cycle();
        @(posedge Clock);
        modelStep();
        @(negedge Clock);
        checkOutput();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        cycle();
        cycle();
        compare("reset IMemReq", {31'b0, IMemReq}, 32'h0);
        compare("reset PCOut", PCOut, 32'h0);
        compare("reset IFIDValid", {31'b0, IFIDValid}, 32'h0);
        compare("reset IFIDInstruction", IFIDInstruction, 32'h0);
        compare("reset IFIDPCPlus4", IFIDPCPlus4, 32'h0);

        // Zero-wait memory after reset release.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        cycle();
        compare("zw IMemReq rise", {31'b0, IMemReq}, 32'h1);
        compare("zw IMemAddr first", IMemAddr, 32'h0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, IMemReq, word_at(IMemAddr));
            cycle();
            compare("zw IFIDValid", {31'b0, IFIDValid}, 32'h1);
            compare("zw IFIDPCPlus4", IFIDPCPlus4, 32'(4 * (k + 1)));
        end
        compare("zw last instr", IFIDInstruction, 32'hA5A5000C);

        // Load-use stall while the word at 0x10 returns.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h8C010004);
        cycle();
        compare("stall IMemReq", {31'b0, IMemReq}, 32'h0);
        compare("stall IFIDPCPlus4 held", IFIDPCPlus4, 32'h10);
        compare("stall IFIDInstruction held", IFIDInstruction, 32'hA5A5000C);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        cycle();
        compare("stall2 IMemReq", {31'b0, IMemReq}, 32'h0);
        compare("stall2 IFIDPCPlus4 held", IFIDPCPlus4, 32'h10);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        cycle();
        compare("release instr", IFIDInstruction, 32'h8C010004);
        compare("release IFIDPCPlus4", IFIDPCPlus4, 32'h14);
        compare("release IMemAddr", IMemAddr, 32'h14);

        // Redirect during a slow request.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0);
        cycle();
        compare("redir IFIDValid", {31'b0, IFIDValid}, 32'h0);
        compare("redir IMemAddr stale", IMemAddr, 32'h14);
        compare("redir PCOut", PCOut, 32'h40);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        cycle();
        compare("drain IMemAddr stale", IMemAddr, 32'h14);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF);
        cycle();
        compare("drain done IMemAddr", IMemAddr, 32'h40);
        compare("drain data dropped", {31'b0, IFIDValid}, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        cycle();
        cycle();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, word_at(32'h40));
        cycle();
        compare("target IFIDPCPlus4", IFIDPCPlus4, 32'h44);
        compare("target instr", IFIDInstruction, 32'hA5A50040);

        // Memory answering every third cycle.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
            cycle();
            cycle();
            compare("slow bubble valid", {31'b0, IFIDValid}, 32'h0);
            compare("slow bubble instr", IFIDInstruction, 32'h0);
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, word_at(32'h44 + 32'(4 * k)));
            cycle();
            compare("slow IFIDPCPlus4", IFIDPCPlus4, 32'h48 + 32'(4 * k));
            compare("slow PCOut", PCOut, 32'h48 + 32'(4 * k));
        end

        // Branch while a word is parked.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h11111111);
        cycle();
        compare("hold IMemReq", {31'b0, IMemReq}, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h103, 1'b0, 32'h0);
        cycle();
        compare("hold-branch IMemAddr", IMemAddr, 32'h100);
        compare("hold-branch IFIDValid", {31'b0, IFIDValid}, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, word_at(32'h100));
        cycle();
        compare("hold-branch next instr", IFIDInstruction, 32'hA5A50100);
        compare("hold-branch next pc4", IFIDPCPlus4, 32'h104);

        // Reset while draining, with stray ready pulses.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0);
        cycle();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'hBAD0BAD0);
        cycle();
        compare("drain-reset PCOut", PCOut, 32'h0);
        compare("drain-reset IMemReq", {31'b0, IMemReq}, 32'h0);
        compare("drain-reset IFIDPCPlus4", IFIDPCPlus4, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'hBAD0BAD0);
        cycle();
        compare("idle stray ready ignored", {31'b0, IFIDValid}, 32'h0);
        compare("idle->fetch IMemAddr", IMemAddr, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, word_at(32'h0));
        cycle();
        compare("post-reset pc4", IFIDPCPlus4, 32'h4);

        // Redirect to the top of memory and wrap around.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b1, 32'h12345678);
        cycle();
        compare("wrap IMemAddr", IMemAddr, 32'hFFFFFFFC);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, word_at(32'hFFFFFFFC));
        cycle();
        compare("wrap IFIDPCPlus4", IFIDPCPlus4, 32'h0);
        compare("wrap PCOut", PCOut, 32'h0);
        compare("wrap instr", IFIDInstruction, 32'h5A5AFFFC);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            applyRandom();
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
